// File: rtl/llc_bus_master_pkg.sv
// Shared bus types for the LLC bus master: operations, bus message, snoop
// results, sequencer states and the pairwise snoop-combine helper.
package pkg_bus;

    typedef enum logic [2:0] {
        BUS_NONE       = 3'b000,
        BUS_READ       = 3'b001,
        BUS_RWIM       = 3'b010,
        BUS_INVALIDATE = 3'b011,
        BUS_WRITE      = 3'b100
    } bus_operation_e;

    typedef enum logic [1:0] {
        SNOOP_NOHIT = 2'b00,
        SNOOP_HIT   = 2'b01,
        SNOOP_HITM  = 2'b10,
        SNOOP_RSVD  = 2'b11
    } snoop_result_e;

    typedef struct packed {
        bus_operation_e operation;
        logic [31:0]    address;
        logic [3:0]     cache_id;
    } bus_msg_st;

    typedef struct packed {
        bus_operation_e op;
        logic [31:0]    addr;
    } req_entry_st;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_ISSUE,
        ST_SNOOP,
        ST_RESP
    } bus_state_e;

    // HITM dominates HIT; anything else, including the reserved code, is NOHIT.
    function automatic snoop_result_e snoop_combine(input snoop_result_e a,
                                                    input snoop_result_e b);
        snoop_result_e r;
        if (a == SNOOP_HITM || b == SNOOP_HITM)
            r = SNOOP_HITM;
        else if (a == SNOOP_HIT || b == SNOOP_HIT)
            r = SNOOP_HIT;
        else
            r = SNOOP_NOHIT;
        return r;
    endfunction

    function automatic logic is_legal_op(input logic [2:0] op);
        return (op >= 3'd1) && (op <= 3'd4);
    endfunction

endpackage

// File: rtl/llc_bus_master_fifo.sv
// Request FIFO for the LLC bus master: power-of-two depth, count-based
// full/empty, pointers wrap naturally.
module llc_bus_req_fifo
    import pkg_bus::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_push,
    input  req_entry_st i_din,
    input  logic        i_pop,
    output req_entry_st o_dout,
    output logic        o_full,
    output logic        o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    req_entry_st     r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [AW:0]     r_count;
    logic            w_push;
    logic            w_pop;

    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_dout  = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr] <= i_din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            if (w_push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (w_pop && !w_push)
                r_count <= r_count - 1'b1;
        end
    end

endmodule

// File: rtl/llc_bus_master.sv
// LLC bus-side request sequencer: FIFO, arbitration, issue, snoop collect, response.
// Define BUS_TRACE_EN for simulation-only trace output of issued/completed ops.
module llc_bus_master
    import pkg_bus::*;
#(
    parameter logic [3:0]  CACHE_ID   = 4'h0,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned SNOOP_WAIT = 2,
    parameter int unsigned NUM_PEERS  = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [2:0]             req_op,
    input  logic [31:0]            req_addr,
    output logic                   bus_req,
    input  logic                   bus_gnt,
    output logic                   bus_valid,
    output logic [38:0]            bus_msg,
    input  logic [2*NUM_PEERS-1:0] snoop_in,
    output logic                   rsp_valid,
    output logic [2:0]             rsp_op,
    output logic [31:0]            rsp_addr,
    output logic [1:0]             rsp_snoop,
    output logic                   busy
);

    localparam int unsigned CW = (SNOOP_WAIT > 1) ? $clog2(SNOOP_WAIT) : 1;

    bus_state_e     r_state;
    bus_state_e     w_next;
    bus_operation_e r_op;
    logic [31:0]    r_addr;
    snoop_result_e  r_snoop;
    snoop_result_e  w_snoop_comb;
    logic [CW-1:0]  r_cnt;
    bus_msg_st      r_msg;
    req_entry_st    w_din;
    req_entry_st    w_head;
    logic           w_full;
    logic           w_empty;
    logic           w_push;
    logic           w_pop;

    // Illegal ops are handshaken but silently dropped.
    assign req_ready = !w_full;
    assign w_push    = req_valid && req_ready && is_legal_op(req_op);
    assign w_pop     = (r_state == ST_IDLE) && !w_empty;
    assign w_din     = '{op: bus_operation_e'(req_op), addr: req_addr};

    llc_bus_req_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   (w_din),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        w_snoop_comb = SNOOP_NOHIT;
        for (int unsigned i = 0; i < NUM_PEERS; i++)
            w_snoop_comb = snoop_combine(w_snoop_comb, snoop_result_e'(snoop_in[2*i +: 2]));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        bus_req   = 1'b0;
        bus_valid = 1'b0;
        rsp_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty)
                    w_next = ST_ARB;
            end
            ST_ARB: begin
                bus_req = 1'b1;
                if (bus_gnt)
                    w_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                bus_req   = 1'b1;
                bus_valid = 1'b1;
                w_next    = (r_op == BUS_WRITE) ? ST_RESP : ST_SNOOP;
            end
            ST_SNOOP: begin
                bus_req = 1'b1;
                if (r_cnt == '0)
                    w_next = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                w_next    = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Snoop result is cleared on pop so WRITE, which skips SNOOP, reports NOHIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op    <= BUS_NONE;
            r_addr  <= '0;
            r_snoop <= SNOOP_NOHIT;
            r_cnt   <= '0;
            r_msg   <= '0;
        end else begin
            if (w_pop) begin
                r_op    <= w_head.op;
                r_addr  <= w_head.addr;
                r_snoop <= SNOOP_NOHIT;
            end
            if (r_state == ST_ARB && bus_gnt)
                r_msg <= '{operation: r_op, address: r_addr, cache_id: CACHE_ID};
            if (r_state == ST_ISSUE)
                r_cnt <= CW'(SNOOP_WAIT - 1);
            if (r_state == ST_SNOOP) begin
                if (r_cnt == '0)
                    r_snoop <= w_snoop_comb;
                else
                    r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign bus_msg   = r_msg;
    assign rsp_op    = r_op;
    assign rsp_addr  = r_addr;
    assign rsp_snoop = r_snoop;
    assign busy      = (r_state != ST_IDLE) || !w_empty;

`ifdef BUS_TRACE_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == ST_ISSUE)
                $display("Busop: %0d, Address: %h", r_op, r_addr);
            if (r_state == ST_RESP)
                $display("Busop: %0d, Address: %h, Snoop Result: %0d", r_op, r_addr, r_snoop);
        end
    end
`endif

endmodule

// File: tb/tb_llc_bus_master.sv
// Self-checking bench for llc_bus_master: queue-based transaction model checked
// every cycle, plus literal latency/value checks for the directed scenarios.
module tb_llc_bus_master;

    localparam int unsigned NP = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [2:0]    req_op;
    logic [31:0]   req_addr;
    logic          bus_req;
    logic          bus_gnt;
    logic          bus_valid;
    logic [38:0]   bus_msg;
    logic [2*NP-1:0] snoop_in;
    logic          rsp_valid;
    logic [2:0]    rsp_op;
    logic [31:0]   rsp_addr;
    logic [1:0]    rsp_snoop;
    logic          busy;

    llc_bus_master #(
        .CACHE_ID   (4'h0),
        .FIFO_DEPTH (4),
        .SNOOP_WAIT (2),
        .NUM_PEERS  (NP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .bus_req   (bus_req),
        .bus_gnt   (bus_gnt),
        .bus_valid (bus_valid),
        .bus_msg   (bus_msg),
        .snoop_in  (snoop_in),
        .rsp_valid (rsp_valid),
        .rsp_op    (rsp_op),
        .rsp_addr  (rsp_addr),
        .rsp_snoop (rsp_snoop),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
    } txn_t;

    txn_t        exp_bus[$];
    txn_t        exp_rsp[$];
    int          errors = 0;
    int          checks = 0;
    int          rsp_count = 0;
    logic [1:0]  last_snoop = 2'b00;
    logic [31:0] last_addr = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Snoop rule: any HITM -> HITM, else any HIT -> HIT, else NOHIT; WRITE is always NOHIT.
    function automatic logic [1:0] model_snoop(input logic [2:0] op, input logic [2*NP-1:0] s);
        int hitm = 0;
        int hit = 0;
        logic [1:0] p;
        if (op == 3'b100)
            return 2'b00;
        for (int i = 0; i < int'(NP); i++) begin
            p = s[2*i +: 2];
            if (p == 2'b10) hitm++;
            else if (p == 2'b01) hit++;
        end
        if (hitm > 0) return 2'b10;
        if (hit > 0) return 2'b01;
        return 2'b00;
    endfunction

    // Advance one cycle, update the model with any accepted request, compare outputs.
    task automatic tick();
        logic        acc;
        logic [2:0]  op;
        logic [31:0] a;
        txn_t        t;
        acc = req_valid && req_ready && !rst;
        op  = req_op;
        a   = req_addr;
        @(posedge clk);
        #1;
        if (acc && op >= 3'b001 && op <= 3'b100) begin
            exp_bus.push_back('{op, a});
            exp_rsp.push_back('{op, a});
        end
        if (!rst) begin
            if (bus_valid) begin
                if (exp_bus.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL bus_unexpected: got msg %h expected none", bus_msg);
                end else begin
                    t = exp_bus.pop_front();
                    check("bus_msg", 64'(bus_msg), 64'({t.op, t.addr, 4'h0}));
                end
            end
            if (rsp_valid) begin
                rsp_count++;
                last_snoop = rsp_snoop;
                last_addr  = rsp_addr;
                if (exp_rsp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: got addr %h expected none", rsp_addr);
                end else begin
                    t = exp_rsp.pop_front();
                    check("rsp_op", 64'(rsp_op), 64'(t.op));
                    check("rsp_addr", 64'(rsp_addr), 64'(t.addr));
                    check("rsp_snoop", 64'(rsp_snoop), 64'(model_snoop(t.op, snoop_in)));
                end
            end
        end
    endtask

    task automatic drain(input string name, input int limit);
        int n = 0;
        while (exp_rsp.size() != 0 && n < limit) begin
            tick();
            n++;
        end
        check({name, "_pending"}, 64'(exp_rsp.size()), 64'd0);
        tick();
    endtask

    task automatic push1(input logic [2:0] op, input logic [31:0] a);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = a;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_req_ready"}, 64'(req_ready), 64'd1);
        check({name, "_bus_req"},   64'(bus_req),   64'd0);
        check({name, "_bus_valid"}, 64'(bus_valid), 64'd0);
        check({name, "_bus_msg"},   64'(bus_msg),   64'd0);
        check({name, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        check({name, "_rsp_op"},    64'(rsp_op),    64'd0);
        check({name, "_rsp_addr"},  64'(rsp_addr),  64'd0);
        check({name, "_rsp_snoop"}, 64'(rsp_snoop), 64'd0);
        check({name, "_busy"},      64'(busy),      64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = 3'b000;
        req_addr  = '0;
        bus_gnt   = 1'b1;
        snoop_in  = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // READ 0x1040, peers {NOHIT, HIT, NOHIT}; cycle 0 is the accept cycle
        snoop_in = 6'b00_01_00;
        push1(3'b001, 32'h0000_1040);                       // now cycle 1
        check("read_c1_busy", 64'(busy), 64'd1);
        tick();                                             // cycle 2
        check("read_c2_bus_req", 64'(bus_req), 64'd1);
        tick();                                             // cycle 3
        check("read_c3_bus_valid", 64'(bus_valid), 64'd1);
        check("read_c3_bus_msg", 64'(bus_msg), 64'h10_0001_0400);
        tick();
        tick();                                             // cycle 5
        check("read_c5_rsp_valid", 64'(rsp_valid), 64'd0);
        tick();                                             // cycle 6
        check("read_c6_rsp_valid", 64'(rsp_valid), 64'd1);
        check("read_c6_rsp_snoop", 64'(rsp_snoop), 64'd1);
        tick();
        check("read_idle_busy", 64'(busy), 64'd0);
        check("read_idle_bus_req", 64'(bus_req), 64'd0);

        // RWIM with peers {HIT, HITM, NOHIT}, then all reserved
        snoop_in = 6'b00_10_01;
        push1(3'b010, 32'h0000_2080);
        drain("rwim_hitm", 20);
        check("rwim_hitm_snoop", 64'(last_snoop), 64'd2);
        snoop_in = 6'b11_11_11;
        push1(3'b010, 32'h0000_2080);
        drain("rwim_rsvd", 20);
        check("rwim_rsvd_snoop", 64'(last_snoop), 64'd0);

        // WRITE skips SNOOP and ignores a HITM peer
        snoop_in = 6'b00_00_10;
        push1(3'b100, 32'hDEAD_BEE0);                       // cycle 1
        tick();
        tick();                                             // cycle 3
        check("write_c3_bus_valid", 64'(bus_valid), 64'd1);
        check("write_c3_bus_msg", 64'(bus_msg), 64'h4D_EADB_EE00);
        tick();                                             // cycle 4
        check("write_c4_rsp_valid", 64'(rsp_valid), 64'd1);
        check("write_c4_rsp_snoop", 64'(rsp_snoop), 64'd0);
        tick();

        // Grant withheld: FIFO fills, bus_req held, FIFO order preserved
        bus_gnt  = 1'b0;
        snoop_in = 6'b00_01_00;
        base     = rsp_count;
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1;
            req_op    = 3'b001;
            req_addr  = 32'h100 * (i + 1);
            check("nognt_ready_accept", 64'(req_ready), 64'd1);
            tick();
        end
        req_addr = 32'h600;
        check("nognt_full_ready", 64'(req_ready), 64'd0);
        for (int i = 0; i < 10; i++) begin
            check("nognt_bus_req", 64'(bus_req), 64'd1);
            check("nognt_ready_held", 64'(req_ready), 64'd0);
            tick();
        end
        bus_gnt = 1'b1;
        n = 0;
        while (!req_ready && n < 30) begin
            tick();
            n++;
        end
        check("nognt_ready_after_pop", 64'(req_ready), 64'd1);
        tick();
        req_valid = 1'b0;
        drain("nognt", 200);
        check("nognt_rsp_count", 64'(rsp_count - base), 64'd6);
        check("nognt_last_addr", 64'(last_addr), 64'h600);

        // Illegal op between two READs is consumed without a response
        base = rsp_count;
        req_valid = 1'b1;
        req_op = 3'b001; req_addr = 32'h700;
        check("illegal_ready0", 64'(req_ready), 64'd1);
        tick();
        req_op = 3'b111; req_addr = 32'h800;
        check("illegal_ready1", 64'(req_ready), 64'd1);
        tick();
        req_op = 3'b001; req_addr = 32'h900;
        check("illegal_ready2", 64'(req_ready), 64'd1);
        tick();
        req_valid = 1'b0;
        drain("illegal", 60);
        check("illegal_rsp_count", 64'(rsp_count - base), 64'd2);
        check("illegal_last_addr", 64'(last_addr), 64'h900);

        // Reset while in SNOOP with two entries queued
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1;
            req_op    = 3'b001;
            req_addr  = 32'hA00 + 32'(i);
            tick();                                         // after loop: cycle 3
        end
        req_valid = 1'b0;
        tick();                                             // cycle 4: SNOOP
        check("rst_pre_bus_req", 64'(bus_req), 64'd1);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_async");
        exp_bus.delete();
        exp_rsp.delete();
        base = rsp_count;
        tick();
        tick();
        rst = 1'b0;
        repeat (15) tick();
        check("rst_no_rsp", 64'(rsp_count - base), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_bus_req", 64'(bus_req), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
